// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the single-port, fixed-latency unified memory
// between instruction fetch (IF, read only) and the MEM stage (loads/stores).
// Every access runs IDLE -> ISSUE -> WAIT (LAT cycles) -> DONE.
// The ack is a one-cycle pulse in DONE.
//
// Parameters: AW address width, DW data width, LAT memory read latency (1..15).
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   if_req/if_addr/if_flush   fetch request, address, cancel in-flight fetch
//   if_ack/if_rdata/if_stall  fetch completion pulse, instruction, stall
//   d_req/d_wr/d_addr/d_wdata data request, store flag, address, store data
//   d_ack/d_rdata/d_stall     data completion pulse, load data, stall
//   halt                      blocks new fetch grants (data is still served)
//   mem_en/mem_wr/mem_addr/mem_wdata  one-cycle access strobe and qualifiers
//   mem_rdata                 read data, valid LAT cycles after the mem_en cycle
//
// Optional build macro MEM_ARB_PERF_CNT_EN adds the saturating 16-bit counters
// if_stall_cnt, d_stall_cnt and conflict_cnt.
module mem_arbiter #(
  parameter int AW  = 16,
  parameter int DW  = 16,
  parameter int LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  input  logic          halt,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
`ifdef MEM_ARB_PERF_CNT_EN
  output logic [15:0]   if_stall_cnt,
  output logic [15:0]   d_stall_cnt,
  output logic [15:0]   conflict_cnt,
`endif
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic       OWNER_IF = 1'b0;
  localparam logic       OWNER_D  = 1'b1;
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t        state_reg, state_next;
  logic [3:0]    cnt_reg;
  logic          owner_reg;
  logic          wr_reg;    // store flag of the current access, kept past ISSUE
  logic          drop_reg;  // in-flight fetch was flushed: no ack, no capture
  logic          mem_wr_reg;
  logic [AW-1:0] mem_addr_reg;
  logic [DW-1:0] mem_wdata_reg;
  logic [DW-1:0] if_rdata_reg, d_rdata_reg;
  logic          grant_d, grant_if;
  logic          last_wait;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next state, grants and strobes
  always_comb begin
    state_next = state_reg;
    grant_d    = 1'b0;
    grant_if   = 1'b0;
    mem_en     = 1'b0;
    if_ack     = 1'b0;
    d_ack      = 1'b0;
    case (state_reg)
      IDLE: begin
        // Data wins: MEM holds the older instruction.
        if (d_req) begin
          grant_d    = 1'b1;
          state_next = ISSUE;
        end else if (if_req && !halt) begin
          grant_if   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_en     = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt_reg == 4'd0) state_next = DONE;
      end
      DONE: begin
        // Requests are not evaluated here: the requester still holds req
        // during its own ack cycle.
        if_ack     = (owner_reg == OWNER_IF) && !drop_reg;
        d_ack      = (owner_reg == OWNER_D);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign last_wait = (state_reg == WAIT) && (cnt_reg == 4'd0);

  // Datapath: access qualifiers, latency counter, ownership, read capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg       <= 4'd0;
      owner_reg     <= OWNER_IF;
      wr_reg        <= 1'b0;
      drop_reg      <= 1'b0;
      mem_wr_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
    end else begin
      // Qualifiers are loaded on the grant edge so they are valid exactly
      // in ISSUE, and fall back to zero on the next edge.
      mem_wr_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if (grant_d) begin
        owner_reg     <= OWNER_D;
        wr_reg        <= d_wr;
        mem_wr_reg    <= d_wr;
        mem_addr_reg  <= d_addr;
        mem_wdata_reg <= d_wr ? d_wdata : '0;
      end else if (grant_if) begin
        owner_reg    <= OWNER_IF;
        wr_reg       <= 1'b0;
        mem_addr_reg <= if_addr;
      end

      if (state_reg == ISSUE)
        cnt_reg <= CNT_INIT;
      else if (state_reg == WAIT && cnt_reg != 4'd0)
        cnt_reg <= cnt_reg - 4'd1;

      if (state_reg == DONE)
        drop_reg <= 1'b0;
      else if (if_flush && owner_reg == OWNER_IF &&
               (state_reg == ISSUE || state_reg == WAIT))
        drop_reg <= 1'b1;

      // A flush arriving in the capture cycle itself must also block the
      // update, hence the direct if_flush term next to drop_reg.
      if (last_wait) begin
        if (owner_reg == OWNER_IF && !drop_reg && !if_flush)
          if_rdata_reg <= mem_rdata;
        if (owner_reg == OWNER_D && !wr_reg)
          d_rdata_reg <= mem_rdata;
      end
    end
  end

  assign mem_wr    = mem_wr_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;

  // Stalls are forced low while reset is held so every output reads zero.
  assign if_stall = if_req & ~if_ack & ~rst;
  assign d_stall  = d_req & ~d_ack & ~rst;

`ifdef MEM_ARB_PERF_CNT_EN
  // Index 0: IF stall cycles, 1: data stall cycles, 2: IDLE-edge conflicts.
  logic [2:0] perf_inc;
  assign perf_inc[0] = if_stall;
  assign perf_inc[1] = d_stall;
  assign perf_inc[2] = (state_reg == IDLE) && d_req && if_req;

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    logic [15:0] cnt_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        cnt_reg <= 16'd0;
      else if (perf_inc[gi] && cnt_reg != 16'hFFFF)
        cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign if_stall_cnt = g_perf[0].cnt_reg;
  assign d_stall_cnt  = g_perf[1].cnt_reg;
  assign conflict_cnt = g_perf[2].cnt_reg;
`endif

endmodule
